// File: rtl/vram_pkg.sv
// Shared VRAM geometry, word type and writer state encoding.
// Latency: none (package only).
// Backpressure: none (package only).
package vram_pkg;

    localparam int VRAM_WORDS = 10924;
    localparam int VRAM_LANES = 6;
    localparam int VRAM_AW    = 14;

    // Lane k of a word occupies bits [8k+7:8k].
    typedef logic [VRAM_LANES-1:0][7:0] vram_word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_CLEAR  = 2'd3
    } vram_wr_state_t;

endpackage

// File: rtl/vram_writer_lane_packer.sv
// Collects stream bytes into lanes of one VRAM word with a pending-enable mask.
// Latency: word_nxt/be_nxt are combinational views including the byte being loaded.
// Backpressure: none; loads whenever the parent asserts load.
module lane_packer
    import vram_pkg::*;
#(
    parameter int LANES = VRAM_LANES,
    localparam int LW   = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic               emit,
    input  logic [7:0]         din,
    output logic [LW-1:0]      lane,
    output logic [LANES*8-1:0] word_nxt,
    output logic [LANES-1:0]   be_nxt
);

    logic [LANES-1:0][7:0] bytes_q;
    logic [LANES-1:0]      pend_q;

    // Word as it will look once the incoming byte lands; empty lanes read as zero.
    always_comb begin
        word_nxt = '0;
        be_nxt   = pend_q;
        for (int k = 0; k < LANES; k++) begin
            if (int'(lane) == k) begin
                word_nxt[8*k +: 8] = din;
                be_nxt[k]          = 1'b1;
            end else if (pend_q[k]) begin
                word_nxt[8*k +: 8] = bytes_q[k];
            end
        end
    end

    // Store bytes lane by lane; an emitted word frees the packer for the next one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane    <= '0;
            pend_q  <= '0;
            bytes_q <= '0;
        end else if (load) begin
            if (emit) begin
                lane    <= '0;
                pend_q  <= '0;
                bytes_q <= '0;
            end else begin
                bytes_q[lane] <= din;
                pend_q[lane]  <= 1'b1;
                lane          <= lane + LW'(1);
            end
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Packs CPU store bytes into 6-lane VRAM words and writes them; optional full-array fill (VRAM_CLEAR_EN).
// Latency: byte handshake at cycle t gives the word write at t+1; clear writes start the cycle after cmd_clear.
// Backpressure: s_ready is high only in STREAM; all outputs registered.
module vram_writer
    import vram_pkg::*;
#(
    parameter int WORDS = VRAM_WORDS,
    parameter int LANES = VRAM_LANES,
    parameter int AW    = VRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_start,
    input  logic [AW-1:0]      cmd_base,
    input  logic               cmd_clear,
    input  logic [7:0]         cmd_fill,
    output logic               busy,
    output logic               done,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [LANES*8-1:0] wr_data,
    output logic [LANES-1:0]   wr_be
);

    localparam int            LW        = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    vram_wr_state_t     state;
    logic [AW-1:0]      ptr;
    logic               hs;
    logic               pk_clr;
    logic               pk_emit;
    logic [LW-1:0]      lane;
    logic [LANES*8-1:0] word_nxt;
    logic [LANES-1:0]   be_nxt;

`ifdef VRAM_CLEAR_EN
    logic [AW-1:0]      clr_cnt;
    logic [7:0]         fill_q;
`else
    logic               unused_clear_pins;
    assign unused_clear_pins = ^{cmd_clear, cmd_fill};
`endif

    assign hs      = s_valid && s_ready;
    assign pk_clr  = (state == ST_IDLE) && cmd_start;
    assign pk_emit = s_last || (lane == LAST_LANE);

    lane_packer #(.LANES(LANES)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pk_clr),
        .load     (hs),
        .emit     (pk_emit),
        .din      (s_data),
        .lane     (lane),
        .word_nxt (word_nxt),
        .be_nxt   (be_nxt)
    );

    // Command FSM with address/clear counters; write outputs default to zero every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_ready <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= '0;
`ifdef VRAM_CLEAR_EN
            clr_cnt <= '0;
            fill_q  <= '0;
`endif
        end else begin
            wr_en   <= 1'b0;
            done    <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= '0;
            case (state)
                ST_IDLE: begin
`ifdef VRAM_CLEAR_EN
                    if (cmd_clear) begin
                        // First fill write is issued straight from the command cycle.
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        fill_q  <= cmd_fill;
                        clr_cnt <= AW'(1);
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= {LANES{cmd_fill}};
                        wr_be   <= '1;
                        done    <= (WORDS == 1);
                    end else if (cmd_start)
`else
                    if (cmd_start)
`endif
                    begin
                        state   <= ST_STREAM;
                        ptr     <= cmd_base;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (hs) begin
                        if (s_last) begin
                            state   <= ST_FLUSH;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                            wr_en   <= 1'b1;
                            wr_addr <= ptr;
                            wr_data <= word_nxt;
                            wr_be   <= be_nxt;
                        end else if (lane == LAST_LANE) begin
                            wr_en   <= 1'b1;
                            wr_addr <= ptr;
                            wr_data <= word_nxt;
                            wr_be   <= be_nxt;
                            ptr     <= (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // The final word is already on the write port this cycle.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
`ifdef VRAM_CLEAR_EN
                ST_CLEAR: begin
                    if (clr_cnt == AW'(WORDS)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= clr_cnt;
                        wr_data <= {LANES{fill_q}};
                        wr_be   <= '1;
                        done    <= (clr_cnt == LAST_ADDR);
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// Directed-vector bench for vram_writer: streaming, partial words, wrap, gaps, reset, clear.
// Latency: checks outputs #1 after each rising edge.
// Backpressure: drives s_valid gaps and busy-time commands.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [13:0] cmd_base;
    logic        cmd_clear;
    logic [7:0]  cmd_fill;
    logic        busy;
    logic        done;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [47:0] wr_data;
    logic [5:0]  wr_be;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vram_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_start (cmd_start),
        .cmd_base  (cmd_base),
        .cmd_clear (cmd_clear),
        .cmd_fill  (cmd_fill),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        st;
        logic [13:0] base;
        logic        clr;
        logic [7:0]  fill;
        logic        vld;
        logic [7:0]  dat;
        logic        last;
        logic        busy;
        logic        done;
        logic        rdy;
        logic        wen;
        logic [13:0] addr;
        logic [47:0] data;
        logic [5:0]  be;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic r, logic st, logic [13:0] base,
                                logic clr, logic [7:0] fill, logic vld, logic [7:0] dat,
                                logic last, logic e_busy, logic e_done, logic e_rdy,
                                logic e_wen, logic [13:0] e_addr, logic [47:0] e_data,
                                logic [5:0] e_be);
        vec_t v;
        v.name = nm;   v.rst = r;       v.st = st;     v.base = base;
        v.clr = clr;   v.fill = fill;   v.vld = vld;   v.dat = dat;   v.last = last;
        v.busy = e_busy; v.done = e_done; v.rdy = e_rdy; v.wen = e_wen;
        v.addr = e_addr; v.data = e_data; v.be = e_be;
        return v;
    endfunction

    task automatic t_reset(string nm, logic vld, logic [7:0] dat);
        vecs.push_back(mk(nm, 1, 0, 0, 0, 0, vld, dat, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic t_idle(string nm, logic vld);
        vecs.push_back(mk(nm, 0, 0, 0, 0, 0, vld, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic t_start(string nm, logic [13:0] base);
        vecs.push_back(mk(nm, 0, 1, base, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    endtask

    task automatic t_byte(string nm, logic [7:0] dat);
        vecs.push_back(mk(nm, 0, 0, 0, 0, 0, 1, dat, 0, 1, 0, 1, 0, 0, 0, 0));
    endtask

    task automatic t_gap(string nm, logic last, logic st, logic [13:0] base);
        vecs.push_back(mk(nm, 0, st, base, 0, 0, 0, 8'hFF, last, 1, 0, 1, 0, 0, 0, 0));
    endtask

    task automatic t_write(string nm, logic [7:0] dat, logic last, logic [13:0] addr,
                           logic [47:0] data, logic [5:0] be);
        vecs.push_back(mk(nm, 0, 0, 0, 0, 0, 1, dat, last, 1, last, !last, 1, addr, data, be));
    endtask

    task automatic check(string nm, logic e_busy, logic e_done, logic e_rdy, logic e_wen,
                         logic [13:0] e_addr, logic [47:0] e_data, logic [5:0] e_be);
        n_vec++;
        if (busy !== e_busy || done !== e_done || s_ready !== e_rdy || wr_en !== e_wen ||
            wr_addr !== e_addr || wr_data !== e_data || wr_be !== e_be) begin
            n_bad++;
            $display("FAIL %s: got busy=%b done=%b rdy=%b wen=%b addr=%0d data=%h be=%h ; want busy=%b done=%b rdy=%b wen=%b addr=%0d data=%h be=%h",
                     nm, busy, done, s_ready, wr_en, wr_addr, wr_data, wr_be,
                     e_busy, e_done, e_rdy, e_wen, e_addr, e_data, e_be);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; cmd_start = 0; cmd_base = 0; cmd_clear = 0; cmd_fill = 0;
        s_valid = 0; s_data = 0; s_last = 0;
    endtask

    initial begin
        idle_inputs();

        // Reset and idle behaviour (stream bytes in IDLE are not accepted).
        t_reset("reset", 0, 0);
        t_idle("idle_vld_ignored", 1);

        // Full word, last on lane 5.
        t_start("full_start", 14'd100);
        t_byte("full_b1", 8'h01);
        t_byte("full_b2", 8'h02);
        t_byte("full_b3", 8'h03);
        t_byte("full_b4", 8'h04);
        t_byte("full_b5", 8'h05);
        t_write("full_w", 8'h06, 1, 14'd100, 48'h060504030201, 6'h3F);
        t_idle("full_after", 0);

        // Eight bytes: one full word then a 2-lane partial word.
        t_start("part_start", 14'd5);
        t_byte("part_b1", 8'h11);
        t_byte("part_b2", 8'h12);
        t_byte("part_b3", 8'h13);
        t_byte("part_b4", 8'h14);
        t_byte("part_b5", 8'h15);
        t_write("part_w0", 8'h16, 0, 14'd5, 48'h161514131211, 6'h3F);
        t_byte("part_b7", 8'h17);
        t_write("part_w1", 8'h18, 1, 14'd6, 48'h000000001817, 6'h03);
        t_idle("part_after", 0);

        // Three-byte stream: lanes 0..2 only.
        t_start("three_start", 14'd7);
        t_byte("three_b1", 8'h61);
        t_byte("three_b2", 8'h62);
        t_write("three_w", 8'h63, 1, 14'd7, 48'h000000636261, 6'h07);
        t_idle("three_after", 0);

        // Address wrap from the top word to 0.
        t_start("wrap_start", 14'd10923);
        t_byte("wrap_b1", 8'h21);
        t_byte("wrap_b2", 8'h22);
        t_byte("wrap_b3", 8'h23);
        t_byte("wrap_b4", 8'h24);
        t_byte("wrap_b5", 8'h25);
        t_write("wrap_w0", 8'h26, 0, 14'd10923, 48'h262524232221, 6'h3F);
        t_byte("wrap_b7", 8'h27);
        t_byte("wrap_b8", 8'h28);
        t_byte("wrap_b9", 8'h29);
        t_byte("wrap_b10", 8'h2A);
        t_byte("wrap_b11", 8'h2B);
        t_write("wrap_w1", 8'h2C, 1, 14'd0, 48'h2C2B2A292827, 6'h3F);
        t_idle("wrap_after", 0);

        // Gaps on s_valid; s_last and a new start during gaps must be ignored.
        t_start("gap_start", 14'd200);
        t_byte("gap_b1", 8'h31);
        t_gap("gap_g1", 1, 1, 14'd999);
        t_byte("gap_b2", 8'h32);
        t_gap("gap_g2", 0, 0, 0);
        t_byte("gap_b3", 8'h33);
        t_gap("gap_g3", 1, 0, 0);
        t_byte("gap_b4", 8'h34);
        t_gap("gap_g4", 0, 1, 14'd3);
        t_byte("gap_b5", 8'h35);
        t_gap("gap_g5", 0, 0, 0);
        t_write("gap_w", 8'h36, 1, 14'd200, 48'h363534333231, 6'h3F);
        t_idle("gap_after", 0);

        // Reset after three bytes discards them; next start packs from lane 0.
        t_start("rst_start", 14'd300);
        t_byte("rst_b1", 8'h41);
        t_byte("rst_b2", 8'h42);
        t_byte("rst_b3", 8'h43);
        t_reset("rst_mid", 1, 8'h44);
        t_idle("rst_after", 0);
        t_start("rst_restart", 14'd0);
        t_byte("rst_c1", 8'h51);
        t_byte("rst_c2", 8'h52);
        t_byte("rst_c3", 8'h53);
        t_byte("rst_c4", 8'h54);
        t_byte("rst_c5", 8'h55);
        t_write("rst_w", 8'h56, 1, 14'd0, 48'h565554535251, 6'h3F);
        t_idle("rst_end", 0);

`ifndef VRAM_CLEAR_EN
        // Without the fill feature cmd_clear is a no-op.
        vecs.push_back(mk("clr_ignored", 0, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t_idle("clr_ignored_after", 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            cmd_start = vecs[i].st;
            cmd_base  = vecs[i].base;
            cmd_clear = vecs[i].clr;
            cmd_fill  = vecs[i].fill;
            s_valid   = vecs[i].vld;
            s_data    = vecs[i].dat;
            s_last    = vecs[i].last;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].busy, vecs[i].done, vecs[i].rdy, vecs[i].wen,
                  vecs[i].addr, vecs[i].data, vecs[i].be);
        end
        idle_inputs();

`ifdef VRAM_CLEAR_EN
        // Clear together with start: clear wins, then 10924 back-to-back fill writes.
        cmd_clear = 1; cmd_start = 1; cmd_base = 14'd50; cmd_fill = 8'hAA;
        @(posedge clk);
        #1;
        idle_inputs();
        cmd_fill = 8'h55;
        for (int a = 0; a < 10924; a++) begin
            check("clear_word", 1, (a == 10923), 0, 1, 14'(a), 48'hAAAAAAAAAAAA, 6'h3F);
            @(posedge clk);
            #1;
        end
        check("clear_exit", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("clear_idle", 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a clear stops the writes.
        cmd_clear = 1; cmd_fill = 8'h0F;
        @(posedge clk);
        #1;
        idle_inputs();
        check("clr2_first", 1, 0, 0, 1, 14'd0, 48'h0F0F0F0F0F0F, 6'h3F);
        @(posedge clk);
        #1;
        check("clr2_second", 1, 0, 0, 1, 14'd1, 48'h0F0F0F0F0F0F, 6'h3F);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("clr2_reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("clr2_after", 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_writer.md
# vram_writer

Write-side port of the vector CPU framebuffer. Accepts a byte stream from the CPU store path and packs it into 48-bit, 6-lane VRAM words. Issues one registered word write per packed word into the same 10924-word VRAM array that the VGA scan-out reads. Optionally performs a hardware clear/fill of the whole framebuffer.

## Interface
Parameters:
- WORDS, 10924, VRAM depth in words
- LANES, 6, bytes per word
- AW, 14, word address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (fixed)
- cmd_start  in  1  one-cycle pulse; begin stream at cmd_base
- cmd_base  in  AW  starting word address (stream always starts at lane 0)
- cmd_clear  in  1  one-cycle pulse; fill entire VRAM (VRAM_CLEAR_EN only)
- cmd_fill  in  8  fill byte for clear
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse marking the final write of a command
- s_valid  in  1  stream byte valid
- s_ready  out  1  stream byte accepted when s_valid && s_ready
- s_data  in  8  stream byte
- s_last  in  1  marks the last byte of the stream
- wr_en  out  1  VRAM word write strobe
- wr_addr  out  AW  VRAM word address
- wr_data  out  48  lane k at bits [8k+7:8k]
- wr_be  out  6  per-lane byte enable

## Operation
- States: IDLE, STREAM, FLUSH, CLEAR.
- IDLE:
  - s_ready=0.
  - cmd_clear → CLEAR; cmd_start → STREAM with ptr=cmd_base, lane=0.
  - If both pulse in the same cycle, cmd_clear wins.
  - Commands arriving while busy are ignored.
- STREAM:
  - s_ready=1.
  - Each handshake stores s_data in the current lane and sets that lane's pending-enable bit.
  - Write trigger: lane==5 and not s_last.
    - Next cycle: wr_en=1, wr_addr=ptr, wr_data=packed word, wr_be=pending bits.
    - lane→0; ptr→ptr+1, wrapping from WORDS-1 to 0.
  - Handshake with s_last → FLUSH.
- FLUSH (one cycle):
  - Emits the final, possibly partial, word.
  - wr_be holds only the filled lanes, e.g. 3 bytes → 6'b000111.
  - done=1; next state IDLE.
- CLEAR:
  - One write per cycle, addresses 0..WORDS-1 in order.
  - wr_be=6'h3F; wr_data={6{cmd_fill}}, with cmd_fill latched on entry.
  - done accompanies the write to WORDS-1; then IDLE.
- Unused lanes of a partial word are driven 0; wr_be masks them out.
- Reset, including mid-stream or mid-clear:
  - State → IDLE.
  - Partial bytes discarded; no write issued.
  - Outputs return to reset values.
- Reset values: busy=0, done=0, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_be=0.

## Timing
- All outputs are registered.
- s_ready is decoded from the state register and is valid the first cycle in STREAM, i.e. the cycle after cmd_start.
- Throughput: one byte per cycle; one word write per 6 bytes.
- Latency: handshake of lane-5 or last byte at cycle t → wr_en at t+1.
- done coincides with the final wr_en; busy drops at the following edge.
- Clear of 10924 words:
  - wr_en spans 10924 consecutive cycles, starting the cycle after cmd_clear.
  - Total clear time: 10925 cycles from cmd_clear to IDLE.
- wr_en is never asserted in IDLE.

## Configuration
- VRAM_CLEAR_EN defined:
  - CLEAR state and fill datapath are present.
  - cmd_clear and cmd_fill are honoured.
- VRAM_CLEAR_EN undefined:
  - CLEAR state is absent.
  - cmd_clear and cmd_fill are ignored; ports remain for pin compatibility.
  - Only streaming is available.

## Structure
- Package vram_pkg holds:
  - constants VRAM_WORDS=10924, VRAM_LANES=6, VRAM_AW=14
  - typedef vram_word_t (6 lanes of 8 bits)
  - state enum vram_wr_state_t
- The VGA path imports the same package constants.
- Sub-module lane_packer: lane counter, byte register file, pending-enable mask, with load/clear controls.
- The FSM, address counter, and clear counter live in vram_writer.

## Test plan
- Full word: start base=100, stream bytes 0x01..0x06 with last on the 6th → one write: addr=100, data=0x060504030201, be=6'h3F; done on the same cycle.
- Partial: base=5, 8 bytes, last on the 8th → writes at addr 5 (be=3F), then addr 6 (be=6'h03, upper lanes 0); done with the second write.
- Wrap: base=10923, 12 bytes → writes at addr 10923 then addr 0.
- Backpressure gaps: s_valid toggles every other cycle over 6 bytes → single write with correct packing; no spurious wr_en.
- Clear (VRAM_CLEAR_EN): cmd_clear with fill=0xAA → 10924 consecutive writes, addr 0..10923, data 0xAAAAAAAAAAAA; done on addr 10923. cmd_clear together with cmd_start → clear wins.
- Reset mid-stream after 3 bytes → no write; outputs 0 next cycle. A subsequent start at base=0 packs from lane 0.
